reg_acumulador_param: RTL and testbench

- Parametrised accumulator register at the ULA output.
- Adds the following to the basic clear/load/hold/load-shift register:
  - configurable width;
  - multi-cycle shift and rotate of the held value by a programmable count (one bit per clock);
  - carry and zero flags;
  - ocupado/pronto handshake toward the control unit.

---
 rtl/reg_acumulador_param_if.sv | 45 ++++
 rtl/reg_acumulador_param.sv | 143 ++++++++++++++
 tb/tb_reg_acumulador_param.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_acumulador_param_if.sv
// Bus between the control unit and the accumulator register.
//   Control unit to register: saida_ula (ULA result), controle (opcode),
//     habilita (command strobe), qtd (shift count for the _N opcodes).
//   Register to control unit: acumulador (held value), carry (last bit out),
//     zero (acumulador == 0), ocupado (multi-cycle shift running),
//     pronto (one-cycle completion pulse).
// The master modport is the control unit; the slave modport is the register.
interface reg_acumulador_param_if #(
   parameter int unsigned LARGURA     = 4,
   parameter int unsigned LARGURA_QTD = $clog2(LARGURA + 1)
);
   logic [LARGURA-1:0]     saida_ula;
   logic [2:0]             controle;
   logic                   habilita;
   logic [LARGURA_QTD-1:0] qtd;
   logic [LARGURA-1:0]     acumulador;
   logic                   carry;
   logic                   zero;
   logic                   ocupado;
   logic                   pronto;

   modport master (
      output saida_ula,
      output controle,
      output habilita,
      output qtd,
      input  acumulador,
      input  carry,
      input  zero,
      input  ocupado,
      input  pronto
   );

   modport slave (
      input  saida_ula,
      input  controle,
      input  habilita,
      input  qtd,
      output acumulador,
      output carry,
      output zero,
      output ocupado,
      output pronto
   );
endinterface

// File: rtl/reg_acumulador_param.sv
// Parametrised accumulator register at the ULA output.
// Single-cycle clear/load/hold/load-shift, plus multi-cycle shift and rotate
// (one bit per clock) of the held value by a programmable count.
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of reg_acumulador_param_if (command inputs, accumulator,
//           carry/zero flags and the ocupado/pronto handshake)
module reg_acumulador_param #(
   parameter int unsigned LARGURA     = 4,
   parameter int unsigned LARGURA_QTD = $clog2(LARGURA + 1)
) (
   input logic                   clock,
   input logic                   reset,
   reg_acumulador_param_if.slave bus
);

   localparam logic [2:0] OpClear   = 3'd0;
   localparam logic [2:0] OpLoad    = 3'd1;
   localparam logic [2:0] OpHold    = 3'd2;
   localparam logic [2:0] OpLoadShl = 3'd3;

   // Low two opcode bits select the multi-cycle operation (opcodes 4..7).
   localparam logic [1:0] ShlN = 2'd0;
   localparam logic [1:0] ShrN = 2'd1;
   localparam logic [1:0] AsrN = 2'd2;
   localparam logic [1:0] RolN = 2'd3;

   typedef enum logic [0:0] {
      StOcioso,
      StDeslocando
   } estado_e;

   estado_e                estado_q, estado_d;
   logic [LARGURA-1:0]     acc_q, acc_d;
   logic                   carry_q, carry_d;
   logic                   ocupado_q, ocupado_d;
   logic                   pronto_q, pronto_d;
   logic [LARGURA_QTD-1:0] contador_q, contador_d;
   logic [1:0]             op_q, op_d;

   always_comb begin
      estado_d   = estado_q;
      acc_d      = acc_q;
      carry_d    = carry_q;
      ocupado_d  = ocupado_q;
      pronto_d   = 1'b0;
      contador_d = contador_q;
      op_d       = op_q;

      unique case (estado_q)
         StOcioso: begin
            if (bus.habilita) begin
               unique case (bus.controle)
                  OpClear: begin
                     acc_d   = '0;
                     carry_d = 1'b0;
                  end
                  OpLoad: begin
                     acc_d   = bus.saida_ula;
                     carry_d = 1'b0;
                  end
                  OpHold: begin
                  end
                  OpLoadShl: begin
                     acc_d   = {bus.saida_ula[LARGURA-2:0], 1'b0};
                     carry_d = bus.saida_ula[LARGURA-1];
                  end
                  default: begin
                     op_d = bus.controle[1:0];
                     if (bus.qtd == '0) begin
                        // Nothing to shift: complete at once, value untouched.
                        pronto_d = 1'b1;
                     end else begin
                        // Counts beyond the width are clamped; the accumulator
                        // itself is only touched on the following edges.
                        contador_d = (bus.qtd > LARGURA_QTD'(LARGURA)) ?
                                     LARGURA_QTD'(LARGURA) : bus.qtd;
                        ocupado_d  = 1'b1;
                        estado_d   = StDeslocando;
                     end
                  end
               endcase
            end
         end
         StDeslocando: begin
            unique case (op_q)
               ShlN: begin
                  acc_d   = {acc_q[LARGURA-2:0], 1'b0};
                  carry_d = acc_q[LARGURA-1];
               end
               ShrN: begin
                  acc_d   = {1'b0, acc_q[LARGURA-1:1]};
                  carry_d = acc_q[0];
               end
               AsrN: begin
                  acc_d   = {acc_q[LARGURA-1], acc_q[LARGURA-1:1]};
                  carry_d = acc_q[0];
               end
               RolN: begin
                  acc_d   = {acc_q[LARGURA-2:0], acc_q[LARGURA-1]};
                  carry_d = acc_q[LARGURA-1];
               end
               default: begin
               end
            endcase
            contador_d = contador_q - LARGURA_QTD'(1);
            if (contador_q == LARGURA_QTD'(1)) begin
               ocupado_d = 1'b0;
               pronto_d  = 1'b1;
               estado_d  = StOcioso;
            end
         end
         default: estado_d = StOcioso;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q   <= StOcioso;
         acc_q      <= '0;
         carry_q    <= 1'b0;
         ocupado_q  <= 1'b0;
         pronto_q   <= 1'b0;
         contador_q <= '0;
         op_q       <= ShlN;
      end else begin
         estado_q   <= estado_d;
         acc_q      <= acc_d;
         carry_q    <= carry_d;
         ocupado_q  <= ocupado_d;
         pronto_q   <= pronto_d;
         contador_q <= contador_d;
         op_q       <= op_d;
      end
   end

   assign bus.acumulador = acc_q;
   assign bus.carry      = carry_q;
   assign bus.zero       = (acc_q == '0);
   assign bus.ocupado    = ocupado_q;
   assign bus.pronto     = pronto_q;

endmodule

// File: tb/tb_reg_acumulador_param.sv
// Directed bench for reg_acumulador_param: a 4-bit instance driven from a
// vector table plus hand-written multi-cycle sequences, and an 8-bit instance
// for a rotate case.
module tb_reg_acumulador_param;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   reg_acumulador_param_if #(.LARGURA(4)) bus4 ();
   reg_acumulador_param_if #(.LARGURA(8)) bus8 ();

   reg_acumulador_param #(.LARGURA(4)) dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   reg_acumulador_param #(.LARGURA(8)) dut8 (
      .clock (clock),
      .reset (reset),
      .bus   (bus8)
   );

   typedef struct packed {
      logic [2:0] ctrl;
      logic       hab;
      logic [3:0] din;
      logic [2:0] qtd;
      logic [3:0] acc;
      logic       carry;
      logic       ocup;
      logic       pronto;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vec [NVEC];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive4(input logic [2:0] c, input logic h, input logic [3:0] d,
                         input logic [2:0] q);
      bus4.controle  = c;
      bus4.habilita  = h;
      bus4.saida_ula = d;
      bus4.qtd       = q;
   endtask

   function automatic vec_t mk(input logic [2:0] c, input logic h, input logic [3:0] d,
                               input logic [2:0] q, input logic [3:0] a, input logic cy,
                               input logic oc, input logic pr);
      vec_t v;
      v.ctrl = c; v.hab = h; v.din = d; v.qtd = q;
      v.acc = a; v.carry = cy; v.ocup = oc; v.pronto = pr;
      return v;
   endfunction

   task automatic chk4(input string nm, input logic [3:0] a, input logic cy,
                       input logic oc, input logic pr);
      chk({nm, ".acc"},     32'(bus4.acumulador), 32'(a));
      chk({nm, ".carry"},   32'(bus4.carry),      32'(cy));
      chk({nm, ".zero"},    32'(bus4.zero),       32'(a == 4'd0));
      chk({nm, ".ocupado"}, 32'(bus4.ocupado),    32'(oc));
      chk({nm, ".pronto"},  32'(bus4.pronto),     32'(pr));
   endtask

   initial begin
      int   ocup_cnt;
      int   k;
      logic pronto_seen;
      logic [3:0] e4;

      // ctrl, hab, din, qtd -> acc, carry, ocupado, pronto after the edge
      vec[0]  = mk(3'd1, 1'b1, 4'b1011, 3'd0, 4'b1011, 1'b0, 1'b0, 1'b0); // LOAD
      vec[1]  = mk(3'd3, 1'b1, 4'b1011, 3'd0, 4'b0110, 1'b1, 1'b0, 1'b0); // LOAD_SHL
      vec[2]  = mk(3'd2, 1'b1, 4'b0000, 3'd0, 4'b0110, 1'b1, 1'b0, 1'b0); // HOLD
      vec[3]  = mk(3'd0, 1'b0, 4'b0000, 3'd0, 4'b0110, 1'b1, 1'b0, 1'b0); // hab=0
      vec[4]  = mk(3'd0, 1'b1, 4'b0000, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0); // CLEAR
      vec[5]  = mk(3'd1, 1'b1, 4'b1011, 3'd0, 4'b1011, 1'b0, 1'b0, 1'b0);
      vec[6]  = mk(3'd5, 1'b1, 4'b0000, 3'd2, 4'b1011, 1'b0, 1'b1, 1'b0); // SHR_N 2
      vec[7]  = mk(3'd0, 1'b0, 4'b0000, 3'd0, 4'b0101, 1'b1, 1'b1, 1'b0);
      vec[8]  = mk(3'd0, 1'b0, 4'b0000, 3'd0, 4'b0010, 1'b1, 1'b0, 1'b1);
      vec[9]  = mk(3'd0, 1'b0, 4'b0000, 3'd0, 4'b0010, 1'b1, 1'b0, 1'b0);
      vec[10] = mk(3'd1, 1'b1, 4'b1000, 3'd0, 4'b1000, 1'b0, 1'b0, 1'b0);
      vec[11] = mk(3'd6, 1'b1, 4'b0000, 3'd3, 4'b1000, 1'b0, 1'b1, 1'b0); // ASR_N 3
      vec[12] = mk(3'd0, 1'b0, 4'b0000, 3'd0, 4'b1100, 1'b0, 1'b1, 1'b0);
      vec[13] = mk(3'd0, 1'b0, 4'b0000, 3'd0, 4'b1110, 1'b0, 1'b1, 1'b0);
      vec[14] = mk(3'd0, 1'b0, 4'b0000, 3'd0, 4'b1111, 1'b0, 1'b0, 1'b1);
      vec[15] = mk(3'd1, 1'b1, 4'b1001, 3'd0, 4'b1001, 1'b0, 1'b0, 1'b0); // back-to-back
      vec[16] = mk(3'd7, 1'b1, 4'b0000, 3'd1, 4'b1001, 1'b0, 1'b1, 1'b0); // ROL_N 1
      vec[17] = mk(3'd0, 1'b0, 4'b0000, 3'd0, 4'b0011, 1'b1, 1'b0, 1'b1);
      vec[18] = mk(3'd1, 1'b1, 4'b0110, 3'd0, 4'b0110, 1'b0, 1'b0, 1'b0);
      vec[19] = mk(3'd4, 1'b1, 4'b0000, 3'd0, 4'b0110, 1'b0, 1'b0, 1'b1); // SHL_N 0
      vec[20] = mk(3'd0, 1'b0, 4'b0000, 3'd0, 4'b0110, 1'b0, 1'b0, 1'b0);

      drive4(3'd2, 1'b0, 4'd0, 3'd0);
      bus8.controle  = 3'd2;
      bus8.habilita  = 1'b0;
      bus8.saida_ula = 8'h00;
      bus8.qtd       = 4'd0;

      // Reset state, then an asynchronous reset in the middle of a cycle.
      #2;
      chk4("rst_init", 4'b0000, 1'b0, 1'b0, 1'b0);
      #1 reset = 1'b0;
      drive4(3'd1, 1'b1, 4'b1010, 3'd0);
      tick();
      chk4("load1010", 4'b1010, 1'b0, 1'b0, 1'b0);
      #3 reset = 1'b1;
      #1;
      chk4("rst_async", 4'b0000, 1'b0, 1'b0, 1'b0);
      drive4(3'd1, 1'b1, 4'b1011, 3'd0);
      tick();
      chk4("rst_held", 4'b0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      chk4("load1011", 4'b1011, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         drive4(vec[i].ctrl, vec[i].hab, vec[i].din, vec[i].qtd);
         tick();
         chk4($sformatf("vec%0d", i), vec[i].acc, vec[i].carry, vec[i].ocup, vec[i].pronto);
      end

      // Clamped SHL_N with LOAD commands presented while busy.
      drive4(3'd1, 1'b1, 4'b1111, 3'd0);
      tick();
      drive4(3'd4, 1'b1, 4'b0000, 3'd7);
      tick();
      chk4("shl7_acc", 4'b1111, 1'b0, 1'b1, 1'b0);
      ocup_cnt = bus4.ocupado ? 1 : 0;
      k = 0;
      while (bus4.ocupado && k < 10) begin
         drive4(3'd1, 1'b1, 4'b0101, 3'd0);
         tick();
         e4 = 4'b1111 << (k + 1);
         chk($sformatf("shl7_step%0d.acc", k), 32'(bus4.acumulador), 32'(e4));
         if (bus4.ocupado) ocup_cnt++;
         k++;
      end
      drive4(3'd2, 1'b0, 4'd0, 3'd0);
      chk("shl7.ocup_cycles", 32'(ocup_cnt), 32'd4);
      chk4("shl7_done", 4'b0000, 1'b1, 1'b0, 1'b1);
      tick();
      chk4("shl7_after", 4'b0000, 1'b1, 1'b0, 1'b0);

      // SHL_N 3 aborted by reset after one shift.
      drive4(3'd1, 1'b1, 4'b0110, 3'd0);
      tick();
      drive4(3'd4, 1'b1, 4'b0000, 3'd3);
      tick();
      drive4(3'd2, 1'b0, 4'd0, 3'd0);
      tick();
      chk4("abort_1shift", 4'b1100, 1'b0, 1'b1, 1'b0);
      #3 reset = 1'b1;
      #1;
      chk4("abort_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
      pronto_seen = 1'b0;
      repeat (2) begin
         tick();
         pronto_seen |= bus4.pronto;
      end
      reset = 1'b0;
      repeat (4) begin
         tick();
         pronto_seen |= bus4.pronto;
      end
      chk("abort.pronto_seen", 32'(pronto_seen), 32'd0);
      chk4("abort_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
      drive4(3'd1, 1'b1, 4'b0101, 3'd0);
      tick();
      chk4("abort_reload", 4'b0101, 1'b0, 1'b0, 1'b0);
      drive4(3'd2, 1'b0, 4'd0, 3'd0);

      // 8-bit instance: 0x81 rotated left by 4.
      bus8.controle  = 3'd1;
      bus8.habilita  = 1'b1;
      bus8.saida_ula = 8'h81;
      tick();
      chk("w8.load", 32'(bus8.acumulador), 32'h81);
      bus8.controle = 3'd7;
      bus8.qtd      = 4'd4;
      tick();
      bus8.habilita = 1'b0;
      chk("w8.accept_acc", 32'(bus8.acumulador), 32'h81);
      ocup_cnt = bus8.ocupado ? 1 : 0;
      k = 0;
      while (!bus8.pronto && k < 20) begin
         tick();
         if (bus8.ocupado) ocup_cnt++;
         k++;
      end
      chk("w8.pronto", 32'(bus8.pronto), 32'd1);
      chk("w8.acc", 32'(bus8.acumulador), 32'h18);
      // Last rotation moves bit 7 of 0x0C (a 0) into bit 0.
      chk("w8.carry", 32'(bus8.carry), 32'd0);
      chk("w8.ocup_cycles", 32'(ocup_cnt), 32'd4);
      chk("w8.zero", 32'(bus8.zero), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
